// File: rtl/mem_stage_hs_if.sv
// rtl/mem_stage_hs_if.sv - peripheral req/ack bus between the MEM stage and the IO fabric
//
// Purpose: groups the variable-latency peripheral bus signals.
// Signals:
//   pr_req  request, held high until pr_ack
//   pr_we   write request
//   pr_addr word address [31:2]
//   pr_be   byte enables
//   pr_wd   lane-replicated write data
//   pr_rd   read data, valid with pr_ack
//   pr_ack  one-cycle completion pulse
// Modports: master (MEM stage), slave (peripheral side).
interface mem_stage_hs_if;
  logic        pr_req;
  logic        pr_we;
  logic [29:0] pr_addr;
  logic [3:0]  pr_be;
  logic [31:0] pr_wd;
  logic [31:0] pr_rd;
  logic        pr_ack;

  modport master (
    output pr_req, pr_we, pr_addr, pr_be, pr_wd,
    input  pr_rd, pr_ack
  );

  modport slave (
    input  pr_req, pr_we, pr_addr, pr_be, pr_wd,
    output pr_rd, pr_ack
  );
endinterface

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - memory-access pipeline stage with local DM and stalling peripheral bus
//
// Purpose: byte-lane generation, local data memory, load extension, and a
// req/ack peripheral path that stalls the pipeline until acknowledged.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds exc_misalign and traps
// misaligned half/word accesses).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   flush           squash the instruction in the stage
//   in_*            EX/MEM register fields (valid, rd, wr, size, sext, regw, rw, addr, wd)
//   stall           freeze upstream stages
//   pr              peripheral bus (master modport)
//   mem_back        forwarding bundle {regw & valid, addr, rw}
//   wb_*            MEM/WB register
//   exc_misalign    misalignment trap (MEM_MISALIGN_TRAP_EN only)
module mem_stage_hs #(
  parameter int          DM_AW   = 12,
  parameter logic [31:0] IO_BASE = 32'h0000_3000,
  parameter int          RW_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_rd,
  input  logic             in_wr,
  input  logic [1:0]       in_size,
  input  logic             in_sext,
  input  logic             in_regw,
  input  logic [RW_W-1:0]  in_rw,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wd,
  output logic             stall,
  mem_stage_hs_if.master   pr,
  output logic [RW_W+32:0] mem_back,
  output logic             wb_valid,
  output logic             wb_regw,
  output logic [RW_W-1:0]  wb_rw,
  output logic [31:0]      wb_alu,
  output logic [31:0]      wb_mem
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic             exc_misalign
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;

  // Byte enables for an access of the given size at the given low address bits.
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   lane_be = 4'b0001 << lo;
      2'b01:   lane_be = 4'b0011 << {lo[1], 1'b0};
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wd(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_wd = {4{wd[7:0]}};
      2'b01:   lane_wd = {2{wd[15:0]}};
      default: lane_wd = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] size, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_ext = {{24{sext & b[7]}}, b};
      2'b01:   load_ext = {{16{sext & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  logic [31:0] dm [2**DM_AW];
  logic [31:0] dm_rd;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic        is_io, live, mem_op, misalign, io_go, dm_we;

  // Request snapshot: the bus must stay stable while waiting, independent of
  // whatever the frozen or flushed upstream presents.
  logic             q_we, q_rd, q_sext, q_regw, q_kill;
  logic [29:0]      q_addr;
  logic [3:0]       q_be;
  logic [31:0]      q_wd, q_alu;
  logic [1:0]       q_lo, q_size;
  logic [RW_W-1:0]  q_rw;

  assign be_c   = lane_be(in_size, in_addr[1:0]);
  assign wd_c   = lane_wd(in_size, in_wd);
  assign dm_rd  = dm[in_addr[DM_AW+1:2]];
  assign is_io  = in_addr[15:0] >= IO_BASE[15:0];
  assign live   = in_valid & ~flush;
  assign mem_op = in_rd | in_wr;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = live & mem_op &
                    (((in_size == 2'b01) & in_addr[0]) | (in_size[1] & (|in_addr[1:0])));
`else
  assign misalign = 1'b0;
`endif

  assign io_go    = live & mem_op & is_io & ~misalign;
  assign dm_we    = (state == IDLE) & live & in_wr & ~is_io & ~misalign;
  assign mem_back = {in_valid & in_regw, in_addr, in_rw};

  always_comb begin
    state_nx   = state;
    stall      = 1'b0;
    pr.pr_req  = 1'b0;
    pr.pr_we   = 1'b0;
    pr.pr_addr = in_addr[31:2];
    pr.pr_be   = be_c;
    pr.pr_wd   = wd_c;
    case (state)
      IDLE: begin
        if (io_go) begin
          pr.pr_req = 1'b1;
          pr.pr_we  = in_wr;
          // A same-cycle ack completes the access with no stall.
          if (!pr.pr_ack) begin
            state_nx = WAIT;
            stall    = 1'b1;
          end
        end
      end
      default: begin
        pr.pr_req  = 1'b1;
        pr.pr_we   = q_we;
        pr.pr_addr = q_addr;
        pr.pr_be   = q_be;
        pr.pr_wd   = q_wd;
        if (pr.pr_ack) state_nx = IDLE;
        else           stall    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q_kill <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) q_kill <= 1'b0;
      else if (flush)    q_kill <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      q_we   <= in_wr;
      q_rd   <= in_rd;
      q_addr <= in_addr[31:2];
      q_be   <= be_c;
      q_wd   <= wd_c;
      q_lo   <= in_addr[1:0];
      q_size <= in_size;
      q_sext <= in_sext;
      q_regw <= in_regw & in_valid;
      q_rw   <= in_rw;
      q_alu  <= in_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (dm_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) dm[in_addr[DM_AW+1:2]][8*i +: 8] <= wd_c[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_regw  <= 1'b0;
      wb_rw    <= '0;
      wb_alu   <= '0;
      wb_mem   <= '0;
    end else if (stall) begin
      wb_valid <= 1'b0;
    end else if (state == WAIT) begin
      // Ack cycle: a flush seen at any point while waiting discards the result.
      wb_valid <= ~(q_kill | flush);
      wb_regw  <= q_regw & ~(q_kill | flush);
      wb_rw    <= q_rw;
      wb_alu   <= q_alu;
      wb_mem   <= q_rd ? load_ext(pr.pr_rd, q_lo, q_size, q_sext) : 32'h0;
    end else begin
      wb_valid <= live;
      wb_regw  <= live & in_regw & ~misalign;
      wb_rw    <= in_rw;
      wb_alu   <= in_addr;
      wb_mem   <= (in_rd & ~misalign)
                  ? load_ext(is_io ? pr.pr_rd : dm_rd, in_addr[1:0], in_size, in_sext)
                  : 32'h0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) exc_misalign <= 1'b0;
    else     exc_misalign <= ~stall & (state == IDLE) & misalign;
  end
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed self-checking bench for mem_stage_hs
//
// Purpose: drives directed vectors on the negative edge and checks combinational
// outputs 1 ns later and MEM/WB outputs 1 ns after each rising edge.
// Ports: none (top-level bench).
module tb_mem_stage_hs;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, in_valid, in_rd, in_wr, in_sext, in_regw;
  logic [1:0]  in_size;
  logic [4:0]  in_rw;
  logic [31:0] in_addr, in_wd;
  logic        stall;
  logic [37:0] mem_back;
  logic        wb_valid, wb_regw;
  logic [4:0]  wb_rw;
  logic [31:0] wb_alu, wb_mem;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        exc_misalign;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_stage_hs_if pr_bus ();

  mem_stage_hs dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_rd    (in_rd),
    .in_wr    (in_wr),
    .in_size  (in_size),
    .in_sext  (in_sext),
    .in_regw  (in_regw),
    .in_rw    (in_rw),
    .in_addr  (in_addr),
    .in_wd    (in_wd),
    .stall    (stall),
    .pr       (pr_bus.master),
    .mem_back (mem_back),
    .wb_valid (wb_valid),
    .wb_regw  (wb_regw),
    .wb_rw    (wb_rw),
    .wb_alu   (wb_alu),
    .wb_mem   (wb_mem)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .exc_misalign (exc_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one instruction at the falling edge; combinational checks follow 1 ns later.
  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic rg, input logic [4:0] rw,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic fl, input logic ack, input logic [31:0] prd);
    @(negedge clk);
    in_valid = v; in_rd = rd; in_wr = wr; in_size = sz; in_sext = sx;
    in_regw = rg; in_rw = rw; in_addr = a; in_wd = wd; flush = fl;
    pr_bus.pr_ack = ack; pr_bus.pr_rd = prd;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'b00, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; in_rd = 0; in_wr = 0; in_size = 0; in_sext = 0; in_regw = 0;
    in_rw = 0; in_addr = 0; in_wd = 0; flush = 0;
    pr_bus.pr_ack = 0; pr_bus.pr_rd = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_regw", wb_regw, 0);
    chk("rst_wb_mem", wb_mem, 0);
    chk("rst_wb_alu", wb_alu, 0);
    chk("rst_pr_req", pr_bus.pr_req, 0);
    chk("rst_pr_we", pr_bus.pr_we, 0);
    chk("rst_stall", stall, 0);
    cyc();
    @(negedge clk) rst = 1'b0;

    // DM word store, then byte loads
    drive(1, 0, 1, 2'b10, 0, 0, 5'd0, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 32'h0);
    chk("st_w_stall", stall, 0);
    chk("st_w_req", pr_bus.pr_req, 0);
    chk("st_w_be", pr_bus.pr_be, 4'hF);
    cyc();
    chk("st_w_wbv", wb_valid, 1);
    chk("st_w_wbregw", wb_regw, 0);
    chk("st_w_wbmem", wb_mem, 0);
    chk("st_w_wbalu", wb_alu, 32'h10);

    drive(1, 1, 0, 2'b00, 1, 1, 5'd5, 32'h0000_0013, 32'h0, 0, 0, 32'h0);
    chk("ldb_stall", stall, 0);
    chk("ldb_memback", mem_back, {1'b1, 32'h0000_0013, 5'd5});
    cyc();
    chk("ldb_sext_mem", wb_mem, 32'hFFFF_FFDE);
    chk("ldb_regw", wb_regw, 1);
    chk("ldb_rw", wb_rw, 5'd5);

    drive(1, 1, 0, 2'b00, 0, 1, 5'd6, 32'h0000_0011, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("ldb_zext_mem", wb_mem, 32'h0000_00BE);

    // Half and byte lane merging into word 0x20
    drive(1, 0, 1, 2'b10, 0, 0, 5'd0, 32'h0000_0020, 32'hAAAA_5555, 0, 0, 32'h0);
    cyc();
    drive(1, 0, 1, 2'b01, 0, 0, 5'd0, 32'h0000_0022, 32'hFFFF_1234, 0, 0, 32'h0);
    chk("st_h_be", pr_bus.pr_be, 4'b1100);
    chk("st_h_wd", pr_bus.pr_wd, 32'h1234_1234);
    cyc();
    drive(1, 1, 0, 2'b01, 0, 1, 5'd7, 32'h0000_0022, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("ldh_zext_mem", wb_mem, 32'h0000_1234);
    drive(1, 1, 0, 2'b10, 0, 1, 5'd7, 32'h0000_0020, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("ldw_merged", wb_mem, 32'h1234_5555);
    drive(1, 0, 1, 2'b00, 0, 0, 5'd0, 32'h0000_0021, 32'h0000_00F0, 0, 0, 32'h0);
    chk("st_b_be", pr_bus.pr_be, 4'b0010);
    chk("st_b_wd", pr_bus.pr_wd, 32'hF0F0_F0F0);
    cyc();
    drive(1, 1, 0, 2'b01, 1, 1, 5'd8, 32'h0000_0020, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("ldh_sext_mem", wb_mem, 32'hFFFF_F055);

    // Non-memory instruction
    drive(1, 0, 0, 2'b10, 0, 1, 5'd9, 32'h1234_5678, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("alu_wbmem", wb_mem, 0);
    chk("alu_wbalu", wb_alu, 32'h1234_5678);
    chk("alu_wbv", wb_valid, 1);

    // IO load, ack on the fourth cycle
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 2'b10, 0, 1, 5'd3, 32'h0000_7F10, 32'h0, 0, 0, 32'h0);
      chk("io_ld_req", pr_bus.pr_req, 1);
      chk("io_ld_addr", pr_bus.pr_addr, 30'h1FC4);
      chk("io_ld_stall", stall, 1);
      cyc();
      chk("io_ld_bubble", wb_valid, 0);
      chk("io_ld_hold_alu", wb_alu, 32'h1234_5678);
    end
    drive(1, 1, 0, 2'b10, 0, 1, 5'd3, 32'h0000_7F10, 32'h0, 0, 1, 32'h0000_0055);
    chk("io_ld_ack_stall", stall, 0);
    chk("io_ld_ack_req", pr_bus.pr_req, 1);
    cyc();
    chk("io_ld_wbv", wb_valid, 1);
    chk("io_ld_wbmem", wb_mem, 32'h55);
    chk("io_ld_wbalu", wb_alu, 32'h7F10);
    chk("io_ld_wbrw", wb_rw, 5'd3);
    idle();
    chk("io_ld_done_req", pr_bus.pr_req, 0);

    // Stray ack with no request
    drive(0, 0, 0, 2'b00, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h0);
    chk("stray_ack_stall", stall, 0);
    cyc();
    idle();
    chk("stray_ack_req", pr_bus.pr_req, 0);

    // IO store acknowledged in the request cycle
    drive(1, 0, 1, 2'b10, 0, 0, 5'd0, 32'h0000_7F00, 32'hCAFE_F00D, 0, 1, 32'h0);
    chk("io_st_req", pr_bus.pr_req, 1);
    chk("io_st_we", pr_bus.pr_we, 1);
    chk("io_st_be", pr_bus.pr_be, 4'hF);
    chk("io_st_wd", pr_bus.pr_wd, 32'hCAFE_F00D);
    chk("io_st_addr", pr_bus.pr_addr, 30'h1FC0);
    chk("io_st_stall", stall, 0);
    cyc();
    chk("io_st_wbv", wb_valid, 1);
    idle();
    chk("io_st_done_req", pr_bus.pr_req, 0);

    // Flush while waiting
    drive(1, 1, 0, 2'b10, 0, 1, 5'd4, 32'h0000_7F20, 32'h0, 0, 0, 32'h0);
    chk("fl_w_stall0", stall, 1);
    cyc();
    drive(1, 1, 0, 2'b10, 0, 1, 5'd4, 32'h0000_7F20, 32'h0, 1, 0, 32'h0);
    chk("fl_w_req1", pr_bus.pr_req, 1);
    chk("fl_w_stall1", stall, 1);
    cyc();
    chk("fl_w_bubble1", wb_valid, 0);
    drive(0, 0, 0, 2'b00, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 32'h0);
    chk("fl_w_req2", pr_bus.pr_req, 1);
    chk("fl_w_addr2", pr_bus.pr_addr, 30'h1FC8);
    cyc();
    drive(0, 0, 0, 2'b00, 0, 0, 5'd0, 32'h0, 32'h0, 0, 1, 32'h0000_0099);
    chk("fl_w_ack_req", pr_bus.pr_req, 1);
    chk("fl_w_ack_stall", stall, 0);
    cyc();
    chk("fl_w_wbv", wb_valid, 0);
    chk("fl_w_wbregw", wb_regw, 0);
    idle();
    chk("fl_w_done_req", pr_bus.pr_req, 0);

    // Reset while waiting
    drive(1, 1, 0, 2'b10, 0, 1, 5'd2, 32'h0000_7F40, 32'h0, 0, 0, 32'h0);
    cyc();
    idle();
    chk("rst_w_req_before", pr_bus.pr_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_w_req", pr_bus.pr_req, 0);
    chk("rst_w_stall", stall, 0);
    @(negedge clk) rst = 1'b0;

    // Flush in IDLE: IO access issues nothing, DM store is suppressed
    drive(1, 1, 0, 2'b10, 0, 1, 5'd2, 32'h0000_7F30, 32'h0, 1, 0, 32'h0);
    chk("fl_i_req", pr_bus.pr_req, 0);
    chk("fl_i_stall", stall, 0);
    cyc();
    chk("fl_i_wbv", wb_valid, 0);
    drive(1, 0, 1, 2'b10, 0, 0, 5'd0, 32'h0000_0010, 32'h0, 1, 0, 32'h0);
    cyc();
    drive(1, 1, 0, 2'b10, 0, 1, 5'd1, 32'h0000_0010, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("fl_i_dm_kept", wb_mem, 32'hDEAD_BEEF);

`ifdef MEM_MISALIGN_TRAP_EN
    drive(1, 0, 1, 2'b10, 0, 0, 5'd0, 32'h0000_0000, 32'h0102_0304, 0, 0, 32'h0);
    cyc();
    drive(1, 0, 1, 2'b10, 0, 1, 5'd1, 32'h0000_0002, 32'h1111_1111, 0, 0, 32'h0);
    chk("mis_req", pr_bus.pr_req, 0);
    cyc();
    chk("mis_exc", exc_misalign, 1);
    chk("mis_wbv", wb_valid, 1);
    chk("mis_wbregw", wb_regw, 0);
    drive(1, 1, 0, 2'b10, 0, 1, 5'd1, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
    cyc();
    chk("mis_exc_clr", exc_misalign, 0);
    chk("mis_dm_kept", wb_mem, 32'h0102_0304);
`endif

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
